// File: rtl/instr_prefetch_if.sv
// Bus bundle for the instruction prefetch queue: ROM fetch port, redirect
// request, and the consumer-side byte stream.
interface instr_prefetch_if;
  logic [15:0] rom_addr;
  logic [7:0]  rom_data;
  logic        fetch_en;
  logic        redirect;
  logic [15:0] redirect_addr;
  logic        byte_valid;
  logic [7:0]  byte_out;
  logic [15:0] byte_pc;
  logic        byte_take;
  logic [3:0]  level;

  modport slave (
    output rom_addr,
    input  rom_data,
    input  fetch_en,
    input  redirect,
    input  redirect_addr,
    output byte_valid,
    output byte_out,
    output byte_pc,
    input  byte_take,
    output level
  );

  modport master (
    input  rom_addr,
    output rom_data,
    output fetch_en,
    output redirect,
    output redirect_addr,
    input  byte_valid,
    input  byte_out,
    input  byte_pc,
    output byte_take,
    input  level
  );
endinterface

// File: rtl/instr_prefetch.sv
// Instruction prefetch queue: fetches bytes from a combinational ROM into a
// circular FIFO of {pc, data} entries; redirect flushes and restarts fetching.
module instr_prefetch #(
  parameter int unsigned DEPTH        = 4,
  parameter logic [15:0] RESET_VECTOR = 16'h0000
) (
  input logic             clk,
  input logic             rst,
  instr_prefetch_if.slave bus
);
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [23:0]   mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [3:0]    count;
  logic [15:0]   pc;
  logic          pop;
  logic          push;

  // Redirect masks both queue events; a pop frees a slot for a same-cycle push.
  always_comb begin
    pop  = bus.byte_take && (count != 4'd0) && !bus.redirect;
    push = bus.fetch_en && !bus.redirect && ((count != 4'(DEPTH)) || pop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc     <= RESET_VECTOR;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (bus.redirect) begin
      pc     <= bus.redirect_addr;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        pc     <= pc + 16'd1;
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + 4'd1;
        2'b01:   count <= count - 4'd1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= {pc, bus.rom_data};
  end

  always_comb begin
    bus.rom_addr   = pc;
    bus.level      = count;
    bus.byte_valid = (count != 4'd0);
    bus.byte_pc    = mem[rd_ptr][23:8];
    bus.byte_out   = mem[rd_ptr][7:0];
  end
endmodule

// File: tb/tb_instr_prefetch.sv
// Directed bench for instr_prefetch: fill, streaming, redirect, wrap,
// empty-pop and asynchronous reset scenarios against hand-computed values.
module tb_instr_prefetch;
  logic clk;
  logic rst;
  int unsigned checks;
  int unsigned failures;

  instr_prefetch_if bus ();

  instr_prefetch #(.DEPTH(4), .RESET_VECTOR(16'h0000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROM: fixed bytes at 0..3, elsewhere low address byte xor 5A.
  function automatic logic [7:0] rom_fn(input logic [15:0] a);
    case (a)
      16'h0000: rom_fn = 8'h01;
      16'h0001: rom_fn = 8'h00;
      16'h0002: rom_fn = 8'h16;
      16'h0003: rom_fn = 8'h48;
      default:  rom_fn = a[7:0] ^ 8'h5A;
    endcase
  endfunction

  always_comb bus.rom_data = rom_fn(bus.rom_addr);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic head(input string tag, input logic [3:0] lvl, input logic [15:0] hpc,
                      input logic [7:0] hdata);
    check({tag, "_level"}, 32'(bus.level), 32'(lvl));
    check({tag, "_valid"}, 32'(bus.byte_valid), 32'd1);
    check({tag, "_pc"}, 32'(bus.byte_pc), 32'(hpc));
    check({tag, "_data"}, 32'(bus.byte_out), 32'(hdata));
  endtask

  task automatic do_redirect(input logic [15:0] a);
    bus.redirect      = 1'b1;
    bus.redirect_addr = a;
    step();
    bus.redirect      = 1'b0;
  endtask

  initial begin
    checks        = 0;
    failures      = 0;
    rst           = 1'b1;
    bus.fetch_en  = 1'b0;
    bus.redirect  = 1'b0;
    bus.redirect_addr = 16'h0000;
    bus.byte_take = 1'b0;

    // Reset state
    step();
    step();
    check("rst_level", 32'(bus.level), 32'd0);
    check("rst_valid", 32'(bus.byte_valid), 32'd0);
    check("rst_addr", 32'(bus.rom_addr), 32'h0000);
    rst = 1'b0;

    // Fill to full
    bus.fetch_en = 1'b1;
    step();
    head("fill1", 4'd1, 16'h0000, 8'h01);
    check("fill1_addr", 32'(bus.rom_addr), 32'h0001);
    step(); step(); step();
    head("full", 4'd4, 16'h0000, 8'h01);
    check("full_addr", 32'(bus.rom_addr), 32'h0004);
    step();
    check("full_hold_level", 32'(bus.level), 32'd4);
    check("full_hold_addr", 32'(bus.rom_addr), 32'h0004);

    // Simultaneous push/pop while full keeps level and FIFO order
    bus.byte_take = 1'b1;
    step();
    head("pp1", 4'd4, 16'h0001, 8'h00);
    step();
    head("pp2", 4'd4, 16'h0002, 8'h16);
    step();
    head("pp3", 4'd4, 16'h0003, 8'h48);
    step();
    head("pp4", 4'd4, 16'h0004, 8'h5E);
    check("pp_addr", 32'(bus.rom_addr), 32'h0008);

    // Redirect then steady stream at level 1
    do_redirect(16'h0100);
    check("rd0_level", 32'(bus.level), 32'd0);
    check("rd0_valid", 32'(bus.byte_valid), 32'd0);
    check("rd0_addr", 32'(bus.rom_addr), 32'h0100);
    step();
    head("st1", 4'd1, 16'h0100, 8'h5A);
    step();
    head("st2", 4'd1, 16'h0101, 8'h5B);
    step();
    head("st3", 4'd1, 16'h0102, 8'h58);

    // Redirect with level 3 and a same-cycle take
    bus.byte_take = 1'b0;
    do_redirect(16'h0020);
    step(); step(); step();
    head("lvl3", 4'd3, 16'h0020, 8'h7A);
    bus.byte_take = 1'b1;
    do_redirect(16'h0040);
    check("rd3_level", 32'(bus.level), 32'd0);
    check("rd3_valid", 32'(bus.byte_valid), 32'd0);
    check("rd3_addr", 32'(bus.rom_addr), 32'h0040);
    bus.byte_take = 1'b0;
    step();
    head("rd3_first", 4'd1, 16'h0040, 8'h1A);

    // Back-to-back redirects: last address wins
    bus.fetch_en = 1'b0;
    bus.redirect = 1'b1;
    bus.redirect_addr = 16'h1234;
    step();
    bus.redirect_addr = 16'h2000;
    step();
    bus.redirect = 1'b0;
    check("b2b_addr", 32'(bus.rom_addr), 32'h2000);
    check("b2b_level", 32'(bus.level), 32'd0);

    // Empty pop with fetch disabled
    bus.byte_take = 1'b1;
    step(); step(); step();
    check("epop_level", 32'(bus.level), 32'd0);
    check("epop_valid", 32'(bus.byte_valid), 32'd0);
    check("epop_addr", 32'(bus.rom_addr), 32'h2000);

    // Address wrap, then drain with fetch disabled
    bus.byte_take = 1'b0;
    bus.fetch_en  = 1'b1;
    do_redirect(16'hFFFE);
    step(); step(); step(); step();
    head("wrap_full", 4'd4, 16'hFFFE, 8'hA4);
    check("wrap_addr", 32'(bus.rom_addr), 32'h0002);
    bus.fetch_en  = 1'b0;
    bus.byte_take = 1'b1;
    step();
    head("wrap1", 4'd3, 16'hFFFF, 8'hA5);
    step();
    head("wrap2", 4'd2, 16'h0000, 8'h01);
    step();
    head("wrap3", 4'd1, 16'h0001, 8'h00);
    check("wrap_addr_hold", 32'(bus.rom_addr), 32'h0002);

    // Asynchronous reset mid-fill
    bus.byte_take = 1'b0;
    bus.fetch_en  = 1'b1;
    do_redirect(16'h0300);
    step(); step();
    check("mid_level", 32'(bus.level), 32'd2);
    #1 rst = 1'b1;
    #1;
    check("arst_valid", 32'(bus.byte_valid), 32'd0);
    check("arst_level", 32'(bus.level), 32'd0);
    check("arst_addr", 32'(bus.rom_addr), 32'h0000);
    rst = 1'b0;
    step();
    head("post_rst", 4'd1, 16'h0000, 8'h01);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
